// File: rtl/tile_scheduler.sv
// -----------------------------------------------------------------------------
// tile_scheduler
//
// Walks a full output feature map in raster-ordered tiles and, for each tile,
// derives the input window (origin, height, width) that a tile_reader must
// fetch, accounting for kernel halo, stride and top/left padding. The reader is
// launched once per tile and the scheduler waits for its done pulse before it
// moves on. A downstream ready gate (tile_ready) keeps tiles from being issued
// faster than the compute core can take them.
//
// Optional build macro: TILE_SCHED_PERF_EN
//   When defined, adds perf_stall_cycles / perf_tile_count counters and ports.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           one-cycle layer start (ignored while busy)
//   cfg_img_h/w, cfg_base_addr      input map description, latched and passed
//                                   through to the reader
//   cfg_out_h/w                     output map dimensions
//   cfg_tile_out_h/w                nominal output tile dimensions (nonzero)
//   cfg_kernel, cfg_stride, cfg_pad kernel size K, stride S (0 means 1), pad P
//   tile_ready                      downstream core can accept a new tile
//   rd_done                         reader finished the current tile
//   rd_start / tile_start           one-cycle launch pulse for the current tile
//   rd_img_h/w, rd_base_addr        latched pass-through configuration
//   rd_tile_in_row/col              signed input window origin
//   rd_tile_in_h/w                  input window dimensions
//   tile_out_row/col                output origin of the current tile
//   tile_out_h/w                    edge-truncated output tile dimensions
//   busy                            high from accepted start until done
//   done                            one-cycle pulse when the layer completes
//   perf_stall_cycles (opt)         cycles spent waiting for tile_ready
//   perf_tile_count   (opt)         tiles issued in the current layer
// -----------------------------------------------------------------------------
module tile_scheduler #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIM_W-1:0]        cfg_img_h,
    input  logic [DIM_W-1:0]        cfg_img_w,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [DIM_W-1:0]        cfg_out_h,
    input  logic [DIM_W-1:0]        cfg_out_w,
    input  logic [DIM_W-1:0]        cfg_tile_out_h,
    input  logic [DIM_W-1:0]        cfg_tile_out_w,
    input  logic [3:0]              cfg_kernel,
    input  logic [1:0]              cfg_stride,
    input  logic [3:0]              cfg_pad,
    input  logic                    tile_ready,
    input  logic                    rd_done,
    output logic                    rd_start,
    output logic [DIM_W-1:0]        rd_img_h,
    output logic [DIM_W-1:0]        rd_img_w,
    output logic [ADDR_W-1:0]       rd_base_addr,
    output logic signed [DIM_W:0]   rd_tile_in_row,
    output logic signed [DIM_W:0]   rd_tile_in_col,
    output logic [DIM_W-1:0]        rd_tile_in_h,
    output logic [DIM_W-1:0]        rd_tile_in_w,
    output logic [DIM_W-1:0]        tile_out_row,
    output logic [DIM_W-1:0]        tile_out_col,
    output logic [DIM_W-1:0]        tile_out_h,
    output logic [DIM_W-1:0]        tile_out_w,
    output logic                    tile_start,
`ifdef TILE_SCHED_PERF_EN
    output logic [31:0]             perf_stall_cycles,
    output logic [DIM_W-1:0]        perf_tile_count,
`endif
    output logic                    busy,
    output logic                    done
);

    // Geometry arithmetic width: wide enough that out_row*S (S <= 3) and the
    // subtraction of P cannot wrap before the final truncation.
    localparam int WW = DIM_W + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    // Latched layer configuration.
    logic [DIM_W-1:0] out_h_q, out_w_q;
    logic [DIM_W-1:0] tile_h_q, tile_w_q;
    logic [3:0]       kernel_q, pad_q;
    logic [1:0]       stride_q;

    // Raster position of the next tile to set up.
    logic [DIM_W-1:0] out_row_q, out_col_q;

    // FSM strobes.
    logic accept, load_geom, fire;

    // Tile geometry derived from the current raster position.
    logic [DIM_W-1:0] rows_left, cols_left, eff_h, eff_w;
    logic [WW-1:0]    stride_w, kernel_w, pad_w, row_w, col_w;

    // Raster advance.
    logic [DIM_W:0]   col_next, row_next;
    logic             wrap_col, last_tile;

    // -------------------------------------------------------------------------
    // Geometry of the tile at (out_row_q, out_col_q). Only registered in SETUP,
    // where out_row_q < out_h_q and out_col_q < out_w_q always hold, so the
    // remaining-extent subtractions cannot underflow there.
    // -------------------------------------------------------------------------
    always_comb begin
        rows_left = out_h_q - out_row_q;
        cols_left = out_w_q - out_col_q;
        eff_h     = (tile_h_q < rows_left) ? tile_h_q : rows_left;
        eff_w     = (tile_w_q < cols_left) ? tile_w_q : cols_left;
        stride_w  = WW'(stride_q);
        kernel_w  = WW'(kernel_q);
        pad_w     = WW'(pad_q);
        row_w     = WW'(out_row_q);
        col_w     = WW'(out_col_q);
    end

    // Raster step uses the registered effective tile size of the tile just
    // completed; one extra bit keeps the end-of-map comparison from wrapping.
    always_comb begin
        col_next  = {1'b0, out_col_q} + {1'b0, tile_out_w};
        row_next  = {1'b0, out_row_q} + {1'b0, tile_out_h};
        wrap_col  = (col_next >= {1'b0, out_w_q});
        last_tile = wrap_col && (row_next >= {1'b0, out_h_q});
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and strobes
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        load_geom = 1'b0;
        fire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (cfg_out_h == '0 || cfg_out_w == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP: begin
                load_geom = 1'b1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (tile_ready) begin
                    fire    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rd_done) begin
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                state_d = last_tile ? S_FINISH : S_SETUP;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers. The pass-through and geometry registers drive ports
    // directly, so they are all reset to keep every output at 0 under reset.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours regardless of the
    // order of statements within this block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_h_q        <= '0;
            out_w_q        <= '0;
            tile_h_q       <= '0;
            tile_w_q       <= '0;
            kernel_q       <= '0;
            pad_q          <= '0;
            stride_q       <= '0;
            out_row_q      <= '0;
            out_col_q      <= '0;
            rd_img_h       <= '0;
            rd_img_w       <= '0;
            rd_base_addr   <= '0;
            rd_tile_in_row <= '0;
            rd_tile_in_col <= '0;
            rd_tile_in_h   <= '0;
            rd_tile_in_w   <= '0;
            tile_out_row   <= '0;
            tile_out_col   <= '0;
            tile_out_h     <= '0;
            tile_out_w     <= '0;
            rd_start       <= 1'b0;
            tile_start     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (accept) begin
                out_h_q      <= cfg_out_h;
                out_w_q      <= cfg_out_w;
                tile_h_q     <= cfg_tile_out_h;
                tile_w_q     <= cfg_tile_out_w;
                kernel_q     <= cfg_kernel;
                pad_q        <= cfg_pad;
                stride_q     <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
                rd_img_h     <= cfg_img_h;
                rd_img_w     <= cfg_img_w;
                rd_base_addr <= cfg_base_addr;
                out_row_q    <= '0;
                out_col_q    <= '0;
                busy         <= 1'b1;
            end else if (state_q == S_FINISH) begin
                busy <= 1'b0;
            end

            // Input window: origin = out*S - P (may be negative at the top/left
            // edge), extent = (eff-1)*S + K.
            if (load_geom) begin
                tile_out_row   <= out_row_q;
                tile_out_col   <= out_col_q;
                tile_out_h     <= eff_h;
                tile_out_w     <= eff_w;
                rd_tile_in_row <= (DIM_W+1)'(row_w * stride_w - pad_w);
                rd_tile_in_col <= (DIM_W+1)'(col_w * stride_w - pad_w);
                rd_tile_in_h   <= DIM_W'((WW'(eff_h) - WW'(1)) * stride_w + kernel_w);
                rd_tile_in_w   <= DIM_W'((WW'(eff_w) - WW'(1)) * stride_w + kernel_w);
            end

            if (state_q == S_ADVANCE) begin
                if (wrap_col) begin
                    out_col_q <= '0;
                    out_row_q <= row_next[DIM_W-1:0];
                end else begin
                    out_col_q <= col_next[DIM_W-1:0];
                end
            end

            rd_start   <= fire;
            tile_start <= fire;
            // Done is high during the FINISH cycle itself, so a start that
            // coincides with it lands outside IDLE and is dropped.
            done       <= (state_d == S_FINISH);
        end
    end

`ifdef TILE_SCHED_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: cleared on an accepted start, saturating, and left
    // untouched after the layer completes so they can be read out afterwards.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_tile_count   <= '0;
        end else if (accept) begin
            perf_stall_cycles <= '0;
            perf_tile_count   <= '0;
        end else begin
            if (state_q == S_ISSUE && !tile_ready && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (fire && perf_tile_count != '1) begin
                perf_tile_count <= perf_tile_count + DIM_W'(1);
            end
        end
    end
`endif

endmodule
